// File: rtl/func_decoder.sv
// Debounced decoder for the display changer's active-low one-hot select.
// Ports: clknew/rst in; lighter[3:0] in; func_sel[1:0], sel_valid,
// sel_change, sel_error out. Macro FUNC_DECODER_SYNC_EN adds a 2-flop
// input synchronizer (default build: lighter sampled directly).
module func_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clknew,
  input  logic       rst,
  input  logic [3:0] lighter,
  output logic [1:0] func_sel,
  output logic       sel_valid,
  output logic       sel_change,
  output logic       sel_error
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_CMT = 8'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  logic [3:0] s;
  logic [3:0] cand;
  logic [7:0] cnt;
  logic       match;
  logic       commit;
  state_t     state_q;
  state_t     state_d;

  logic       code_legal;
  logic       code_blank;
  logic [1:0] code_idx;

  logic [1:0] func_sel_d;
  logic       sel_valid_d;
  logic       sel_change_d;
  logic       sel_error_d;

`ifdef FUNC_DECODER_SYNC_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  // Reset to the blank code so a held-off display looks idle.
  always_ff @(posedge clknew or posedge rst) begin
    if (rst) begin
      sync_q1 <= 4'b1111;
      sync_q2 <= 4'b1111;
    end else begin
      sync_q1 <= lighter;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = lighter;
`endif

  assign match  = (s == cand);
  // The saturated counter can never equal CNT_CMT again until the
  // run restarts, so each stable run commits at most once.
  assign commit = match && (cnt == CNT_CMT);

  always_ff @(posedge clknew or posedge rst) begin
    if (rst) begin
      cand <= 4'b1111;
      cnt  <= 8'd0;
    end else if (!match) begin
      cand <= s;
      cnt  <= 8'd0;
    end else if (cnt < CNT_MAX) begin
      cnt  <= cnt + 8'd1;
    end
  end

  always_comb begin
    code_legal = 1'b1;
    code_blank = 1'b0;
    code_idx   = 2'd0;
    unique case (s)
      4'b1110: code_idx = 2'd0;
      4'b1101: code_idx = 2'd1;
      4'b1011: code_idx = 2'd2;
      4'b0111: code_idx = 2'd3;
      4'b1111: begin
        code_legal = 1'b0;
        code_blank = 1'b1;
      end
      default: code_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clknew or posedge rst) begin
    if (rst) state_q <= ST_WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: begin
        if (!match)      state_d = ST_SETTLE;
        else if (commit) state_d = ST_LOCKED;
      end
      ST_SETTLE: begin
        if (commit)      state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!match)      state_d = ST_SETTLE;
      end
      default:           state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    func_sel_d   = func_sel;
    sel_valid_d  = sel_valid;
    sel_error_d  = sel_error;
    sel_change_d = 1'b0;
    if (commit && (state_q != ST_LOCKED)) begin
      unique case (1'b1)
        code_legal: begin
          sel_change_d = !sel_valid || (code_idx != func_sel);
          func_sel_d   = code_idx;
          sel_valid_d  = 1'b1;
          sel_error_d  = 1'b0;
        end
        code_blank: begin
          sel_valid_d  = 1'b0;
          sel_error_d  = 1'b0;
        end
        default: begin
          sel_valid_d  = 1'b0;
          sel_error_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clknew or posedge rst) begin
    if (rst) begin
      func_sel   <= 2'b00;
      sel_valid  <= 1'b0;
      sel_change <= 1'b0;
      sel_error  <= 1'b0;
    end else begin
      func_sel   <= func_sel_d;
      sel_valid  <= sel_valid_d;
      sel_change <= sel_change_d;
      sel_error  <= sel_error_d;
    end
  end

endmodule

// File: tb/tb_func_decoder.sv
// Scoreboard bench for func_decoder (STABLE_CYCLES=4).
// Latency follows FUNC_DECODER_SYNC_EN as seen by this file.
module tb_func_decoder;

  localparam int SC = 4;
`ifdef FUNC_DECODER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = SC + SYNC;

  logic       clknew;
  logic       rst;
  logic [3:0] lighter;
  logic [1:0] func_sel;
  logic       sel_valid;
  logic       sel_change;
  logic       sel_error;

  func_decoder #(.STABLE_CYCLES(SC)) dut (
    .clknew    (clknew),
    .rst       (rst),
    .lighter   (lighter),
    .func_sel  (func_sel),
    .sel_valid (sel_valid),
    .sel_change(sel_change),
    .sel_error (sel_error)
  );

  initial clknew = 1'b0;
  always #5 clknew = ~clknew;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: run-length of the synchronized sample stream.
  logic [3:0] pipe0, pipe1, m_prev;
  int         m_run;
  logic [1:0] m_fs;
  logic       m_valid, m_err;
  logic [4:0] exp_q[$];

  int edge_no, pulses, first_pulse;

  task automatic model_reset();
    pipe0   = 4'b1111;
    pipe1   = 4'b1111;
    m_prev  = 4'b1111;
    m_run   = 1;
    m_fs    = 2'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [3:0] l);
    logic [3:0] sv;
    logic       hit;
    logic       ch;
    sv = (SYNC == 2) ? pipe1 : l;
    pipe1 = pipe0;
    pipe0 = l;
    hit = 1'b0;
    ch  = 1'b0;
    if (sv == m_prev) begin
      if (m_run == SC - 1) hit = 1'b1;
      if (m_run < SC) m_run++;
    end else begin
      m_prev = sv;
      m_run  = 1;
    end
    if (hit) begin
      case (sv)
        4'b1110, 4'b1101, 4'b1011, 4'b0111: begin
          logic [1:0] idx;
          idx = (sv == 4'b1110) ? 2'd0 :
                (sv == 4'b1101) ? 2'd1 :
                (sv == 4'b1011) ? 2'd2 : 2'd3;
          ch      = !m_valid || (idx != m_fs);
          m_fs    = idx;
          m_valid = 1'b1;
          m_err   = 1'b0;
        end
        4'b1111: begin
          m_valid = 1'b0;
          m_err   = 1'b0;
        end
        default: begin
          m_valid = 1'b0;
          m_err   = 1'b1;
        end
      endcase
    end
    exp_q.push_back({m_fs, m_valid, ch, m_err});
  endtask

  function automatic logic [31:0] outs();
    return 32'({func_sel, sel_valid, sel_change, sel_error});
  endfunction

  task automatic step(input logic [3:0] l);
    logic [4:0] e;
    lighter = l;
    model_edge(l);
    @(posedge clknew);
    edge_no++;
    @(negedge clknew);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("out@%0d", edge_no), outs(), 32'(e));
    end
    if (sel_change) begin
      pulses++;
      if (first_pulse == 0) first_pulse = edge_no;
    end
  endtask

  task automatic hold(input logic [3:0] l, input int n);
    for (int i = 0; i < n; i++) step(l);
  endtask

  task automatic clr_stats();
    pulses      = 0;
    first_pulse = 0;
  endtask

  // Assert reset at a negedge, check outputs clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", outs(), 32'd0);
    @(posedge clknew);
    @(negedge clknew);
    check("rst_hold", outs(), 32'd0);
    rst = 1'b0;
    model_reset();
    edge_no = 0;
    clr_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    lighter = 4'b1111;
    edge_no = 0;
    clr_stats();
    model_reset();
    @(negedge clknew);
    @(negedge clknew);
    do_reset();

    // First commit lands exactly LAT edges after the new value.
    hold(4'b1110, 10);
    check("first_edge", 32'(first_pulse), 32'(LAT));
    check("first_cnt", 32'(pulses), 32'd1);

    clr_stats();
    hold(4'b1101, 10);
    hold(4'b1011, 10);
    hold(4'b0111, 10);
    hold(4'b1110, 10);
    check("walk_cnt", 32'(pulses), 32'd4);
    check("walk_fs", 32'(func_sel), 32'd0);

    clr_stats();
    hold(4'b1011, 3);
    hold(4'b1110, 10);
    check("short_cnt", 32'(pulses), 32'd0);
    check("short_vld", 32'(sel_valid), 32'd1);

    clr_stats();
    hold(4'b1100, 10);
    check("bad_err", 32'(sel_error), 32'd1);
    check("bad_vld", 32'(sel_valid), 32'd0);
    check("bad_fs", 32'(func_sel), 32'd0);
    check("bad_cnt", 32'(pulses), 32'd0);
    hold(4'b0111, 10);
    check("rec_cnt", 32'(pulses), 32'd1);
    check("rec_fs", 32'(func_sel), 32'd3);
    check("rec_err", 32'(sel_error), 32'd0);

    clr_stats();
    hold(4'b1111, 10);
    check("blank_vld", 32'(sel_valid), 32'd0);
    check("blank_err", 32'(sel_error), 32'd0);
    check("blank_fs", 32'(func_sel), 32'd3);
    check("blank_cnt", 32'(pulses), 32'd0);

    clr_stats();
    hold(4'b1110, 10);
    check("pre_cnt", 32'(pulses), 32'd1);
    clr_stats();
    hold(4'b1101, 1);
    hold(4'b1110, 8);
    check("glitch_cnt", 32'(pulses), 32'd0);
    check("glitch_fs", 32'(func_sel), 32'd0);

    // Reset mid-settle, one edge short of the commit.
    hold(4'b1101, LAT - 1);
    do_reset();
    hold(4'b1101, LAT + 4);
    check("rst_edge", 32'(first_pulse), 32'(LAT));
    check("rst_cnt", 32'(pulses), 32'd1);
    check("rst_fs", 32'(func_sel), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
